// File: rtl/irq_latch4_pkg.sv
// Shared definitions for the irq_latch4 interrupt latch: channel count, id width
// and the presentation FSM encoding.
package irq_latch4_pkg;

  localparam int NUM_CH = 4;
  localparam int ID_W   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    CLEAR   = 2'd2
  } state_t;

endpackage

// File: rtl/irq_latch4_edge_sync4.sv
// Per-channel multi-flop synchronizer followed by a registered rising-edge detector.
// Produces a one-cycle rise pulse per channel.
module edge_sync4
  import irq_latch4_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req_in,
  output logic [NUM_CH-1:0] rise
);

  localparam logic [1:0] ARM_LAST = 2'(SYNC_STAGES);

  logic [NUM_CH-1:0] w_sync_out;
  logic [NUM_CH-1:0] r_hist;
  logic [NUM_CH-1:0] r_rise;
  logic [1:0]        r_arm_cnt;
  logic              r_armed;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], req_in[gi]};
        end
      end

      assign w_sync_out[gi] = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // Edges stay suppressed until the chain and history hold real samples, so a
  // level that was already high when reset was released never looks like a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist    <= '0;
      r_rise    <= '0;
      r_arm_cnt <= '0;
      r_armed   <= 1'b0;
    end else begin
      r_hist <= w_sync_out;
      r_rise <= r_armed ? (w_sync_out & ~r_hist) : '0;
      if (!r_armed) begin
        if (r_arm_cnt == ARM_LAST) begin
          r_armed <= 1'b1;
        end else begin
          r_arm_cnt <= r_arm_cnt + 2'd1;
        end
      end
    end
  end

  assign rise = r_rise;

endmodule

// File: rtl/irq_latch4.sv
// Four-channel interrupt latch: synchronized edges set pending bits, a priority
// FSM presents one channel until acked. Optional overflow flags: IRQ_LATCH4_OVF_EN.
module irq_latch4
  import irq_latch4_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req_in,
  input  logic [NUM_CH-1:0] mask,
  output logic [NUM_CH-1:0] pend,
  output logic              irq_valid,
  output logic [ID_W-1:0]   irq_id,
  input  logic              irq_ack
`ifdef IRQ_LATCH4_OVF_EN
  , output logic [NUM_CH-1:0] ovf
`endif
);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_valid;
  logic              w_valid_next;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   w_id_next;
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_clr;
  logic [NUM_CH-1:0] w_elig;
  logic [ID_W-1:0]   w_top_id;
  logic              w_any;

  edge_sync4 #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync4 (
    .clk   (clk),
    .rst_n (rst_n),
    .req_in(req_in),
    .rise  (w_rise)
  );

  assign w_elig = r_pend & mask;
  assign w_any  = |w_elig;

  // Ascending scan: the last eligible index found is the highest priority one.
  always_comb begin
    w_top_id = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_elig[i]) begin
        w_top_id = ID_W'(i);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_clr
      assign w_clr[gi] = (r_state == PRESENT) && irq_ack && (r_id == ID_W'(gi));
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_valid_next = r_valid;
    w_id_next    = r_id;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_id_next    = w_top_id;
          w_valid_next = 1'b1;
          w_state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (irq_ack) begin
          w_valid_next = 1'b0;
          w_state_next = CLEAR;
        end
      end
      CLEAR: begin
        w_valid_next = 1'b0;
        w_state_next = IDLE;
      end
      default: begin
        w_valid_next = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  // A rise on the channel being cleared keeps it pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_next;
      r_valid <= w_valid_next;
      r_id    <= w_id_next;
      r_pend  <= (r_pend & ~w_clr) | w_rise;
    end
  end

  assign pend      = r_pend;
  assign irq_valid = r_valid;
  assign irq_id    = r_id;

`ifdef IRQ_LATCH4_OVF_EN
  logic [NUM_CH-1:0] r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= (r_ovf & ~w_clr) | (w_rise & r_pend);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_irq_latch4.sv
// Self-checking bench for irq_latch4: vector table, hand-written corner sequences
// and randomized traffic against a behavioural model.
module tb_irq_latch4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_in;
  logic [3:0] mask;
  logic [3:0] pend;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic       irq_ack;
`ifdef IRQ_LATCH4_OVF_EN
  logic [3:0] ovf;
`endif

  always #5 clk = ~clk;

  irq_latch4 #(
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .mask     (mask),
    .pend     (pend),
    .irq_valid(irq_valid),
    .irq_id   (irq_id),
    .irq_ack  (irq_ack)
`ifdef IRQ_LATCH4_OVF_EN
    , .ovf    (ovf)
`endif
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] msk;
    logic       ack;
    logic [3:0] exp_pend;
    logic       exp_valid;
    logic [1:0] exp_id;
  } vec_t;

  vec_t vecs[19];

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: input samples since reset, pending set, presentation phase.
  logic [3:0] m_q[$];
  logic [3:0] m_pend;
  logic [3:0] m_ovf;
  logic       m_valid;
  logic       m_gap;
  logic [1:0] m_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] highest(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) return 2'(i);
    end
    return 2'd0;
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_pend  = '0;
    m_ovf   = '0;
    m_valid = 1'b0;
    m_gap   = 1'b0;
    m_id    = '0;
  endfunction

  // One clock edge: a 0->1 change between two consecutive post-reset samples
  // becomes pending three edges after the later sample.
  function automatic void model_edge(input logic [3:0] r, input logic [3:0] m, input logic a);
    logic [3:0] rise;
    logic [3:0] clr;
    logic [3:0] old_pend;
    int n;
    m_q.push_back(r);
    n = m_q.size();
    rise = '0;
    if (n >= 5) rise = m_q[n-4] & ~m_q[n-5];
    clr = (m_valid && a) ? (4'b0001 << m_id) : 4'b0000;
    old_pend = m_pend;
    if (m_valid) begin
      if (a) begin
        m_valid = 1'b0;
        m_gap   = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if ((old_pend & m) != 4'b0000) begin
      m_valid = 1'b1;
      m_id    = highest(old_pend & m);
    end
    m_ovf  = (m_ovf & ~clr) | (rise & old_pend);
    m_pend = (old_pend & ~clr) | rise;
  endfunction

  task automatic tick(input logic [3:0] r, input logic [3:0] m, input logic a);
    req_in  = r;
    mask    = m;
    irq_ack = a;
    @(posedge clk);
    #1;
    model_edge(r, m, a);
    chk("model_pend", pend, m_pend);
    chk("model_valid", irq_valid, m_valid);
    if (m_valid) chk("model_id", irq_id, m_id);
`ifdef IRQ_LATCH4_OVF_EN
    chk("model_ovf", ovf, m_ovf);
`endif
  endtask

  task automatic do_reset(input logic [3:0] r);
    rst_n   = 1'b0;
    req_in  = r;
    mask    = 4'hF;
    irq_ack = 1'b0;
    #1;
    chk("rst_async_valid", irq_valid, 1'b0);
    chk("rst_async_pend", pend, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pend", pend, 4'h0);
    chk("rst_valid", irq_valid, 1'b0);
    chk("rst_id", irq_id, 2'd0);
`ifdef IRQ_LATCH4_OVF_EN
    chk("rst_ovf", ovf, 4'h0);
`endif
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] m;

    vecs[0]  = '{4'h2, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0};
    vecs[1]  = '{4'h2, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0};
    vecs[2]  = '{4'h2, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0};
    vecs[3]  = '{4'h2, 4'hF, 1'b1, 4'h2, 1'b0, 2'd0};
    vecs[4]  = '{4'h2, 4'hF, 1'b0, 4'h2, 1'b1, 2'd1};
    vecs[5]  = '{4'h2, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0};
    vecs[6]  = '{4'h2, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0};
    vecs[7]  = '{4'h0, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0};
    vecs[8]  = '{4'h0, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0};
    vecs[9]  = '{4'hA, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0};
    vecs[10] = '{4'hA, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0};
    vecs[11] = '{4'hA, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0};
    vecs[12] = '{4'hA, 4'hF, 1'b0, 4'hA, 1'b0, 2'd0};
    vecs[13] = '{4'hA, 4'hF, 1'b0, 4'hA, 1'b1, 2'd3};
    vecs[14] = '{4'hA, 4'hF, 1'b1, 4'h2, 1'b0, 2'd0};
    vecs[15] = '{4'hA, 4'hF, 1'b1, 4'h2, 1'b0, 2'd0};
    vecs[16] = '{4'hA, 4'hF, 1'b0, 4'h2, 1'b1, 2'd1};
    vecs[17] = '{4'hA, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0};
    vecs[18] = '{4'h0, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0};

    rst_n   = 1'b0;
    req_in  = '0;
    mask    = '0;
    irq_ack = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Level already high across reset release creates no edge.
    do_reset(4'hF);
    repeat (20) tick(4'hF, 4'hF, 1'b0);
    chk("hold_high_pend", pend, 4'h0);
    chk("hold_high_valid", irq_valid, 1'b0);

    // Vector table: single channel, then two channels in priority order.
    do_reset(4'h0);
    repeat (6) tick(4'h0, 4'hF, 1'b0);
    for (int i = 0; i < 19; i++) begin
      tick(vecs[i].req, vecs[i].msk, vecs[i].ack);
      chk($sformatf("vec%0d_pend", i), pend, vecs[i].exp_pend);
      chk($sformatf("vec%0d_valid", i), irq_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_id", i), irq_id, vecs[i].exp_id);
    end

    // Masked channel stays pending, presented once unmasked.
    repeat (2) tick(4'h0, 4'h7, 1'b0);
    repeat (5) tick(4'h8, 4'h7, 1'b0);
    chk("masked_pend", pend, 4'h8);
    chk("masked_valid", irq_valid, 1'b0);
    tick(4'h8, 4'hF, 1'b0);
    chk("unmask_valid", irq_valid, 1'b1);
    chk("unmask_id", irq_id, 2'd3);
    tick(4'h8, 4'hF, 1'b1);
    chk("unmask_ack_pend", pend, 4'h0);
    repeat (2) tick(4'h0, 4'hF, 1'b0);

    // Presentation held while mask drops and no ack arrives.
    repeat (5) tick(4'h4, 4'hF, 1'b0);
    chk("hold_valid_start", irq_valid, 1'b1);
    chk("hold_id_start", irq_id, 2'd2);
    for (int i = 0; i < 10; i++) begin
      tick(4'h4, 4'h0, 1'b0);
      chk($sformatf("hold%0d_valid", i), irq_valid, 1'b1);
      chk($sformatf("hold%0d_id", i), irq_id, 2'd2);
    end
    tick(4'h4, 4'h0, 1'b1);
    chk("hold_ack_pend", pend, 4'h0);
    repeat (2) tick(4'h0, 4'h0, 1'b0);

    // Second edge on a pending channel is absorbed.
    repeat (5) tick(4'h1, 4'hF, 1'b0);
    chk("absorb_valid", irq_valid, 1'b1);
    chk("absorb_id", irq_id, 2'd0);
    repeat (2) tick(4'h0, 4'hF, 1'b0);
    repeat (4) tick(4'h1, 4'hF, 1'b0);
`ifdef IRQ_LATCH4_OVF_EN
    chk("absorb_ovf", ovf, 4'h1);
`endif
    chk("absorb_pend", pend, 4'h1);
    tick(4'h1, 4'hF, 1'b1);
    chk("absorb_ack_pend", pend, 4'h0);
`ifdef IRQ_LATCH4_OVF_EN
    chk("absorb_ack_ovf", ovf, 4'h0);
`endif
    repeat (6) tick(4'h1, 4'hF, 1'b0);
    chk("absorb_no_second", irq_valid, 1'b0);

    // New edge coinciding with the clear keeps the channel pending.
    repeat (2) tick(4'h0, 4'hF, 1'b0);
    repeat (5) tick(4'h1, 4'hF, 1'b0);
    repeat (2) tick(4'h0, 4'hF, 1'b0);
    repeat (3) tick(4'h1, 4'hF, 1'b0);
    tick(4'h1, 4'hF, 1'b1);
    chk("setwins_pend", pend, 4'h1);
    chk("setwins_clear_valid", irq_valid, 1'b0);
    tick(4'h1, 4'hF, 1'b0);
    tick(4'h1, 4'hF, 1'b0);
    chk("setwins_repres_valid", irq_valid, 1'b1);
    chk("setwins_repres_id", irq_id, 2'd0);
    tick(4'h1, 4'hF, 1'b1);
    tick(4'h1, 4'hF, 1'b0);

    // Reset in the middle of a presentation, request level still high.
    repeat (2) tick(4'h0, 4'hF, 1'b0);
    repeat (5) tick(4'h2, 4'hF, 1'b0);
    chk("midrst_pre_valid", irq_valid, 1'b1);
    do_reset(4'h2);
    repeat (10) tick(4'h2, 4'hF, 1'b0);
    chk("midrst_pend", pend, 4'h0);
    chk("midrst_valid", irq_valid, 1'b0);

    // Randomized traffic against the model.
    do_reset(4'h0);
    r = 4'h0;
    m = 4'hF;
    repeat (6) tick(r, m, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      r = r ^ 4'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) m = 4'($urandom);
      tick(r, m, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_latch4.md
IRQ_LATCH4 -- requirements
Module: irq_latch4

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops per request line (legal range 2..3).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, the reset; asynchronous and active-low.
REQ-004 SHALL have port req_in, input, 4 bits, asynchronous request lines; bit 3 has the highest priority.
REQ-005 SHALL have port mask, input, 4 bits, synchronous enable; 1 = channel eligible for presentation.
REQ-006 SHALL have port pend, output, 4 bits, registered pending vector; drives the D input of the downstream 4-to-2 priority encoder.
REQ-007 SHALL have port irq_valid, output, 1 bit, registered; 1 = a request is presented on irq_id.
REQ-008 SHALL have port irq_id, output, 2 bits, registered index of the presented channel.
REQ-009 SHALL have port irq_ack, input, 1 bit; the consumer accepts the presented request.

Function
REQ-010 SHALL pass each req_in bit through SYNC_STAGES flops, then a rising-edge detector (sync output 0 -> 1).
REQ-011 SHALL set pend[i] on the cycle after a detected rising edge on channel i; pend[i] is set regardless of mask[i].
REQ-012 SHALL give, with SYNC_STAGES=2, req_in rising before edge N -> pend set after edge N+3 -> irq_valid high after edge N+4 (FSM in IDLE).
REQ-013 SHALL implement FSM states IDLE, PRESENT and CLEAR.
REQ-014 In IDLE, if (pend & mask) != 0: load irq_id with the highest set index of (pend & mask), set irq_valid, go to PRESENT; otherwise stay.
REQ-015 In PRESENT, SHALL hold irq_valid=1 and irq_id stable until irq_ack=1 is sampled, even if mask or pend change meanwhile.
REQ-016 On irq_ack in PRESENT: clear pend[irq_id], drop irq_valid, go to CLEAR.
REQ-017 CLEAR SHALL last exactly one cycle with irq_valid=0, then return to IDLE; the minimum spacing between presentations is 2 cycles.
REQ-018 irq_ack SHALL be ignored in IDLE and CLEAR.
REQ-019 SHALL keep pend[i] set if a new edge on channel i coincides with its clear (set wins).
REQ-020 An edge on an already-pending channel SHALL be absorbed: pend stays 1 and no second presentation occurs.
REQ-021 SHALL never present a channel whose pend bit is 0; if mask becomes 0 in IDLE, irq_valid stays 0.

Reset
REQ-022 While rst_n=0, SHALL force sync flops, edge history, pend=4'b0000, irq_valid=0, irq_id=2'b00 and FSM=IDLE immediately.
REQ-023 Reset asserted mid-PRESENT SHALL drop the request without requiring an ack; a req_in level already high at reset release SHALL NOT create an edge.

Configuration
REQ-024 Macro IRQ_LATCH4_OVF_EN defined: adds output ovf (4 bits, reset 0); ovf[i] is set when an edge hits an already-set pend[i] (including the set-wins case) and is cleared together with pend[i] on ack.
REQ-025 Macro IRQ_LATCH4_OVF_EN undefined: the ovf port and its logic are absent; all other behaviour is identical.

Structure
REQ-026 Shared package SHALL hold the FSM state encoding (IDLE=2'd0, PRESENT=2'd1, CLEAR=2'd2), channel count 4 and the id width of 2.
REQ-027 Synchronizer plus edge detector SHALL be one sub-module, edge_sync4 (parameter SYNC_STAGES; outputs a 4-bit one-cycle rise pulse).
REQ-028 Priority selection SHALL stay inside irq_latch4.

Verification
REQ-029 Reset with req_in=4'b1111 held, then release -> pend=0000 and irq_valid=0 indefinitely.
REQ-030 mask=1111, req_in 0000 -> 0010 -> pend=0010 after 3 edges, irq_valid=1 and irq_id=01 after 4; ack -> pend=0000, one CLEAR cycle.
REQ-031 mask=1111, req_in 0000 -> 1010 at once -> irq_id=11 first; ack -> CLEAR -> irq_id=01; ack -> pend=0000.
REQ-032 mask=0111, edge on bit 3 -> pend=1000, irq_valid stays 0; mask -> 1111 -> irq_id=11 on the next cycle.
REQ-033 irq_id=10 presented, mask -> 0000 with no ack for 10 cycles -> irq_valid=1 and irq_id=10 held throughout; then ack -> pend[2] cleared.
REQ-034 With IRQ_LATCH4_OVF_EN: second edge on bit 0 while pend[0]=1 -> ovf=0001, one presentation only; ack -> ovf=0000 and pend=0000.
